// File: rtl/serial_arith_pkg.sv
// ---------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial arithmetic family.
//   state_e : control states (IDLE, ADD, DONE) used by the serial engines
//   maj3    : three-input majority, i.e. the carry of a full adder
// ---------------------------------------------------------------------------
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// ---------------------------------------------------------------------------
// serial_addsub_if
// Request/result bundle for serial_addsub.
//   en, a, b, sub          : start request and operands (master -> slave)
//   busy, done             : status (slave -> master)
//   out, cout, ovf         : result, carry out, signed overflow (slave -> master)
// Modports: master (requester / testbench), slave (the adder).
// ---------------------------------------------------------------------------
interface serial_addsub_if #(
  parameter int WIDTH = 8
) ();

  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;

  modport master (
    output en, a, b, sub,
    input  busy, done, out, cout, ovf
  );

  modport slave (
    input  en, a, b, sub,
    output busy, done, out, cout, ovf
  );

endinterface

// File: rtl/serial_addsub_fa_bit.sv
// ---------------------------------------------------------------------------
// fa_bit
// Combinational one-bit full adder; the single bit slice of the serial adder.
//   a, b, cin : addend bits and carry in
//   s         : sum bit
//   cout      : carry out
// ---------------------------------------------------------------------------
module fa_bit
  import serial_arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = maj3(a, b, cin);

endmodule

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
// Bit-serial two's-complement adder/subtractor, one bit per clock, LSB first.
// Subtraction is A + ~B + 1: B is inverted at capture and the carry is
// preloaded with 1.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : serial_addsub_if.slave (en/a/b/sub in; busy/done/out/cout/ovf out)
// Accepting edge -> WIDTH further edges -> DONE for one cycle -> IDLE.
// ---------------------------------------------------------------------------
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             rst,
  serial_addsub_if.slave  bus
);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] out_q;
  logic [CNT_W-1:0] count_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             sum_d;
  logic             carry_d;
  logic             last_bit;

  fa_bit u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (sum_d),
    .cout (carry_d)
  );

  assign last_bit = (count_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.en) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub;
            count_q <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end

        ADD: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_d;
          out_q   <= {sum_d, out_q[WIDTH-1:1]};
          // Hold at WIDTH-1 on the last bit so the counter never wraps,
          // even when WIDTH is a power of two.
          count_q <= last_bit ? count_q : count_q + CNT_W'(1);
          if (last_bit) begin
            cout_q  <= carry_d;
            // carry_q is the carry into the MSB, carry_d the carry out of it.
            ovf_q   <= carry_q ^ carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
// Drives an 8-bit and a 16-bit serial_addsub with directed vectors. Each
// accepted start pushes its hand-computed result onto a per-instance queue;
// a separate monitor samples on the falling edge and pops/compares whenever
// done is high, and otherwise checks reset values and held results.
// ---------------------------------------------------------------------------
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   finish_req = 1'b0;

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    int          acc;
    string       name;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  logic [15:0] hold_o8 = '0;
  logic        hold_c8 = 1'b0;
  logic        hold_v8 = 1'b0;
  logic [15:0] hold_o16 = '0;
  logic        hold_c16 = 1'b0;
  logic        hold_v16 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub_if #(.WIDTH(8))  bus8  ();
  serial_addsub_if #(.WIDTH(16)) bus16 ();

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_addsub #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Present a start request for one cycle; optionally record its expectation.
  task automatic start_op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] eo, input logic ec,
                          input logic ev, input bit push, input string nm);
    @(negedge clk);
    if (w16) begin
      bus16.en = 1'b1; bus16.a = a; bus16.b = b; bus16.sub = s;
    end else begin
      bus8.en = 1'b1; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.sub = s;
    end
    @(posedge clk);
    #1;
    if (push) begin
      if (w16) q16.push_back('{res: eo, cout: ec, ovf: ev, acc: cyc, name: nm});
      else     q8.push_back('{res: eo, cout: ec, ovf: ev, acc: cyc, name: nm});
    end
    bus8.en  = 1'b0;
    bus16.en = 1'b0;
  endtask

  task automatic op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                    input logic s, input logic [15:0] eo, input logic ec,
                    input logic ev, input string nm);
    start_op(w16, a, b, s, eo, ec, ev, 1'b1, nm);
    repeat ((w16 ? 16 : 8) + 2) @(posedge clk);
  endtask

  // Stimulus
  initial begin
    bus8.en = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.sub = 1'b0;
    bus16.en = 1'b0; bus16.a = '0; bus16.b = '0; bus16.sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    op(1'b0, 16'h005A, 16'h0033, 1'b0, 16'h008D, 1'b0, 1'b1, "add_5a_33");
    op(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ff_01");
    op(1'b0, 16'h0010, 16'h0020, 1'b1, 16'h00F0, 1'b0, 1'b0, "sub_10_20");
    op(1'b0, 16'h0080, 16'h0001, 1'b1, 16'h007F, 1'b1, 1'b1, "sub_80_01");
    op(1'b0, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1, "add_7f_01");
    op(1'b0, 16'h0033, 16'h0033, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_33_33");
    op(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, "add16_ffff_ffff");
    op(1'b1, 16'h1234, 16'h0235, 1'b1, 16'h0FFF, 1'b1, 1'b0, "sub16_1234_0235");

    // Requests held high through ADD and DONE must be ignored.
    start_op(1'b0, 16'h005A, 16'h0033, 1'b0, 16'h008D, 1'b0, 1'b1, 1'b1, "ignore_5a_33");
    bus8.en = 1'b1; bus8.a = 8'h00; bus8.b = 8'h00; bus8.sub = 1'b1;
    repeat (9) @(posedge clk);
    #1 bus8.en = 1'b0; bus8.sub = 1'b0;
    repeat (3) @(posedge clk);

    // Abort mid-operation at count 4; no result is expected from it.
    start_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, "abort");
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    op(1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "add_after_rst");
    repeat (2) @(posedge clk);
    finish_req = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_zero8",  {bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.out}, 64'h0);
        check("rst_zero16", {bus16.busy, bus16.done, bus16.cout, bus16.ovf, bus16.out}, 64'h0);
        hold_o8 = '0;  hold_c8 = 1'b0;  hold_v8 = 1'b0;
        hold_o16 = '0; hold_c16 = 1'b0; hold_v16 = 1'b0;
      end else begin
        if (bus8.done) begin
          if (q8.size() == 0) begin
            check("unexpected_done8", 64'(bus8.done), 64'h0);
          end else begin
            e = q8.pop_front();
            check({e.name, ".out"},  64'(bus8.out),  64'(e.res));
            check({e.name, ".cout"}, 64'(bus8.cout), 64'(e.cout));
            check({e.name, ".ovf"},  64'(bus8.ovf),  64'(e.ovf));
            check({e.name, ".latency"}, 64'(cyc - e.acc), 64'd8);
            hold_o8 = e.res; hold_c8 = e.cout; hold_v8 = e.ovf;
          end
        end else if (!bus8.busy) begin
          check("hold8", {bus8.ovf, bus8.cout, 8'h00, bus8.out}, {hold_v8, hold_c8, hold_o8});
        end

        if (bus16.done) begin
          if (q16.size() == 0) begin
            check("unexpected_done16", 64'(bus16.done), 64'h0);
          end else begin
            e = q16.pop_front();
            check({e.name, ".out"},  64'(bus16.out),  64'(e.res));
            check({e.name, ".cout"}, 64'(bus16.cout), 64'(e.cout));
            check({e.name, ".ovf"},  64'(bus16.ovf),  64'(e.ovf));
            check({e.name, ".latency"}, 64'(cyc - e.acc), 64'd16);
            hold_o16 = e.res; hold_c16 = e.cout; hold_v16 = e.ovf;
          end
        end else if (!bus16.busy) begin
          check("hold16", {bus16.ovf, bus16.cout, bus16.out}, {hold_v16, hold_c16, hold_o16});
        end
      end

      if (finish_req) begin
        check("pending8",  64'(q8.size()),  64'h0);
        check("pending16", 64'(q16.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH), bit-counter width; derived, not overridden.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  start request, sampled only in IDLE.
REQ-006 SHALL have port a  input  WIDTH  operand A, captured on accepted start.
REQ-007 SHALL have port b  input  WIDTH  operand B, captured on accepted start.
REQ-008 SHALL have port sub  input  1  mode, captured on accepted start: 0 = A+B, 1 = A-B.
REQ-009 SHALL have port busy  output  1  high in ADD state.
REQ-010 SHALL have port done  output  1  high for exactly one cycle in DONE state.
REQ-011 SHALL have port out  output  WIDTH  result, (A op B) mod 2^WIDTH.
REQ-012 SHALL have port cout  output  1  final carry out of bit WIDTH-1; for subtract, 1 = no borrow.
REQ-013 SHALL have port ovf  output  1  two's-complement signed overflow of the operation.

Function
REQ-014 SHALL implement states IDLE, ADD, DONE only.
REQ-015 IDLE: en=1 at clock edge SHALL load a_reg<=a, b_reg<=(sub ? ~b : b), carry<=sub, count<=0, out<=0, clear cout/ovf, go ADD; en=0 SHALL stay IDLE with all outputs held.
REQ-016 ADD: each cycle SHALL compute bit sum=a_reg[0]^b_reg[0]^carry, carry<=majority(a_reg[0],b_reg[0],carry), shift a_reg/b_reg right by 1, shift sum into out MSB (out<={sum,out[WIDTH-1:1]}), count<=count+1.
REQ-017 ADD with count==WIDTH-1 SHALL, on the same edge as the last bit, write cout<=final carry, ovf<=(carry into MSB) XOR (final carry), and go DONE.
REQ-018 DONE SHALL last one cycle and return to IDLE unconditionally.
REQ-019 Latency SHALL be WIDTH+1 edges from the accepting edge to the edge that enters DONE; done high for the following cycle.
REQ-020 out, cout, ovf SHALL hold their final values from DONE until the next accepted start.
REQ-021 en, a, b, sub changes during ADD or DONE SHALL be ignored; no queuing of requests.
REQ-022 en=1 in the DONE cycle SHALL be ignored; a new start is accepted only in the next IDLE cycle (minimum period WIDTH+2 cycles).
REQ-023 Counter SHALL never wrap within an operation; counter value outside ADD is don't-care but SHALL be deterministic.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, out=0, cout=0, ovf=0, carry=0, count=0, a_reg=0, b_reg=0, busy=0, done=0.
REQ-025 rst asserted mid-operation SHALL abort it with no done pulse; the first edge after deassert behaves as IDLE.

Structure
REQ-026 State encoding SHALL be a typedef enum (IDLE, ADD, DONE) in shared package serial_arith_pkg, reused by future serial arithmetic blocks.
REQ-027 Single sub-module fa_bit (combinational full adder: a, b, cin -> s, cout) SHALL be instantiated once for the bit slice.

Verification
REQ-028 WIDTH=8, sub=0, a=0x5A, b=0x33 -> done after 9 edges, out=0x8D, cout=0, ovf=1.
REQ-029 WIDTH=8, sub=0, a=0xFF, b=0x01 -> out=0x00, cout=1, ovf=0.
REQ-030 WIDTH=8, sub=1, a=0x10, b=0x20 -> out=0xF0, cout=0, ovf=0; a=0x80, b=0x01 -> out=0x7F, cout=1, ovf=1.
REQ-031 WIDTH=16, sub=0, a=0xFFFF, b=0xFFFF -> done after 17 edges, out=0xFFFE, cout=1, ovf=0.
REQ-032 Start 0x5A+0x33, then drive en=1, a=0x00, b=0x00 during ADD and DONE -> result still 0x8D, exactly one done pulse.
REQ-033 Assert rst at ADD count=4 -> all outputs 0 at once, no done; new start after deassert 0x01+0x01 -> out=0x02.
